// File: rtl/mcpu_control_if.sv
// Control bundle between the multi-cycle MIPS main controller and its datapath.
// The controller takes the master view: it observes the IR fields and the
// ALU zero flag, and it drives every enable and select in the datapath.
interface mcpu_control_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       pc_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_zero;
    logic [1:0] pc_source;
    logic [3:0] alu_ctrl;
    logic       instr_done;
    logic [3:0] state;

    modport master (
        input  opcode, funct, zero,
        output pc_write, iord, mem_read, mem_write, ir_write, reg_write,
               reg_dst, mem_to_reg, alu_src_a, alu_src_b, ext_zero,
               pc_source, alu_ctrl, instr_done, state
    );

    modport slave (
        output opcode, funct, zero,
        input  pc_write, iord, mem_read, mem_write, ir_write, reg_write,
               reg_dst, mem_to_reg, alu_src_a, alu_src_b, ext_zero,
               pc_source, alu_ctrl, instr_done, state
    );
endinterface

// File: rtl/mcpu_control.sv
// Main control FSM of the multi-cycle MIPS CPU. Moore decode of the state
// register, except for the branch-taken PC load and the NOP completion in
// DECODE. All controls are forced low while rst_n is low.
module mcpu_control (
    input  logic           clk,
    input  logic           rst_n,
    mcpu_control_if.master bus
);
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD = 4'd3,
        S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_RTEX   = 4'd6,  S_RTWB  = 4'd7,
        S_BRANCH = 4'd8,  S_ITEX   = 4'd9,  S_ITWB   = 4'd10, S_JUMP  = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_BEQ  = 6'h04,
                           OP_BNE   = 6'h05, OP_ADDI = 6'h08, OP_SLTI = 6'h0A,
                           OP_ANDI  = 6'h0C, OP_ORI  = 6'h0D, OP_XORI = 6'h0E,
                           OP_LW    = 6'h23, OP_SW   = 6'h2B;

    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2,
                           ALU_OR  = 4'd3, ALU_XOR = 4'd4, ALU_NOR = 4'd5,
                           ALU_SLT = 4'd6;

    state_t     state_reg;
    state_t     state_next;
    logic       rt_ok;
    logic [3:0] rt_alu;
    logic       it_ok;
    logic [3:0] it_alu;
    logic       it_ez;

    // State register; reset returns to FETCH regardless of the current state.
    always_ff @(posedge clk) begin
        if (!rst_n) state_reg <= S_FETCH;
        else        state_reg <= state_next;
    end

    // R-type funct decode into an ALU operation, flagging unsupported functs.
    always_comb begin
        rt_ok  = 1'b1;
        rt_alu = ALU_ADD;
        case (bus.funct)
            6'h20:   rt_alu = ALU_ADD;
            6'h22:   rt_alu = ALU_SUB;
            6'h24:   rt_alu = ALU_AND;
            6'h25:   rt_alu = ALU_OR;
            6'h26:   rt_alu = ALU_XOR;
            6'h27:   rt_alu = ALU_NOR;
            6'h2A:   rt_alu = ALU_SLT;
            default: rt_ok  = 1'b0;
        endcase
    end

    // I-type ALU opcode decode; logical immediates are zero-extended.
    always_comb begin
        it_ok  = 1'b1;
        it_alu = ALU_ADD;
        it_ez  = 1'b0;
        case (bus.opcode)
            OP_ADDI: it_alu = ALU_ADD;
            OP_SLTI: it_alu = ALU_SLT;
            OP_ANDI: begin it_alu = ALU_AND; it_ez = 1'b1; end
            OP_ORI:  begin it_alu = ALU_OR;  it_ez = 1'b1; end
            OP_XORI: begin it_alu = ALU_XOR; it_ez = 1'b1; end
            default: it_ok  = 1'b0;
        endcase
    end

    // Next-state and per-state control outputs, gated off during reset.
    always_comb begin
        state_next     = S_FETCH;
        bus.pc_write   = 1'b0;
        bus.iord       = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.ir_write   = 1'b0;
        bus.reg_write  = 1'b0;
        bus.reg_dst    = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = 2'b00;
        bus.ext_zero   = 1'b0;
        bus.pc_source  = 2'b00;
        bus.alu_ctrl   = ALU_ADD;
        bus.instr_done = 1'b0;
        case (state_reg)
            S_FETCH: begin
                bus.mem_read  = 1'b1;
                bus.ir_write  = 1'b1;
                bus.pc_write  = 1'b1;
                bus.alu_src_b = 2'b01;
                state_next    = S_DECODE;
            end
            S_DECODE: begin
                bus.alu_src_b = 2'b11;
                if (bus.opcode == OP_LW || bus.opcode == OP_SW)
                    state_next = S_MEMADR;
                else if (bus.opcode == OP_RTYPE && rt_ok)
                    state_next = S_RTEX;
                else if (bus.opcode == OP_BEQ || bus.opcode == OP_BNE)
                    state_next = S_BRANCH;
                else if (it_ok)
                    state_next = S_ITEX;
                else if (bus.opcode == OP_J)
                    state_next = S_JUMP;
                else
                    bus.instr_done = 1'b1;  // unsupported: retire as a NOP
            end
            S_MEMADR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                state_next    = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                bus.mem_read = 1'b1;
                bus.iord     = 1'b1;
                state_next   = S_MEMWB;
            end
            S_MEMWB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
                bus.instr_done = 1'b1;
            end
            S_MEMWR: begin
                bus.mem_write  = 1'b1;
                bus.iord       = 1'b1;
                bus.instr_done = 1'b1;
            end
            S_RTEX: begin
                bus.alu_src_a = 1'b1;
                bus.alu_ctrl  = rt_alu;
                state_next    = S_RTWB;
            end
            S_RTWB: begin
                bus.reg_write  = 1'b1;
                bus.reg_dst    = 1'b1;
                bus.instr_done = 1'b1;
            end
            S_BRANCH: begin
                bus.alu_src_a  = 1'b1;
                bus.alu_ctrl   = ALU_SUB;
                bus.pc_source  = 2'b01;
                bus.instr_done = 1'b1;
                bus.pc_write   = (bus.opcode == OP_BEQ &&  bus.zero) ||
                                 (bus.opcode == OP_BNE && !bus.zero);
            end
            S_ITEX: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                bus.alu_ctrl  = it_alu;
                bus.ext_zero  = it_ez;
                state_next    = S_ITWB;
            end
            S_ITWB: begin
                bus.reg_write  = 1'b1;
                bus.instr_done = 1'b1;
            end
            S_JUMP: begin
                bus.pc_write   = 1'b1;
                bus.pc_source  = 2'b10;
                bus.instr_done = 1'b1;
            end
            default: state_next = S_FETCH;  // codes 12-15: outputs stay 0
        endcase
        if (!rst_n) begin
            bus.pc_write   = 1'b0;
            bus.iord       = 1'b0;
            bus.mem_read   = 1'b0;
            bus.mem_write  = 1'b0;
            bus.ir_write   = 1'b0;
            bus.reg_write  = 1'b0;
            bus.reg_dst    = 1'b0;
            bus.mem_to_reg = 1'b0;
            bus.alu_src_a  = 1'b0;
            bus.alu_src_b  = 2'b00;
            bus.ext_zero   = 1'b0;
            bus.pc_source  = 2'b00;
            bus.alu_ctrl   = ALU_ADD;
            bus.instr_done = 1'b0;
        end
    end

    assign bus.state = state_reg;
endmodule

// File: tb/tb_mcpu_control.sv
// Scoreboard bench for mcpu_control: each scenario queues one entry per cycle
// holding the stimulus for that cycle and the expected control word, then the
// queue is drained one clock at a time against the DUT.
module tb_mcpu_control;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    mcpu_control_if bus ();

    mcpu_control dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] state;
        logic       pc_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       ext_zero;
        logic [1:0] pc_source;
        logic [3:0] alu_ctrl;
        logic       instr_done;
    } ctl_t;

    typedef struct {
        string      name;
        logic       rst;
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        ctl_t       exp;
    } entry_t;

    entry_t q[$];
    int tests = 0;
    int fails = 0;

    // Expected control word for a state, straight from the state output table.
    function automatic ctl_t ex(input logic [3:0] st, input logic [3:0] alu,
                                input logic ez, input logic pcw, input logic done);
        ctl_t c;
        c = '0;
        c.state = st;
        case (st)
            4'd0:  begin c.mem_read = 1; c.ir_write = 1; c.pc_write = 1; c.alu_src_b = 2'b01; end
            4'd1:  begin c.alu_src_b = 2'b11; c.instr_done = done; end
            4'd2:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
            4'd3:  begin c.mem_read = 1; c.iord = 1; end
            4'd4:  begin c.reg_write = 1; c.mem_to_reg = 1; c.instr_done = 1; end
            4'd5:  begin c.mem_write = 1; c.iord = 1; c.instr_done = 1; end
            4'd6:  begin c.alu_src_a = 1; c.alu_ctrl = alu; end
            4'd7:  begin c.reg_write = 1; c.reg_dst = 1; c.instr_done = 1; end
            4'd8:  begin c.alu_src_a = 1; c.alu_ctrl = 4'd1; c.pc_source = 2'b01;
                         c.instr_done = 1; c.pc_write = pcw; end
            4'd9:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; c.alu_ctrl = alu; c.ext_zero = ez; end
            4'd10: begin c.reg_write = 1; c.instr_done = 1; end
            4'd11: begin c.pc_write = 1; c.pc_source = 2'b10; c.instr_done = 1; end
            default: c = '0;
        endcase
        return c;
    endfunction

    // All controls low, state visible.
    function automatic ctl_t held(input logic [3:0] st);
        ctl_t c;
        c = '0;
        c.state = st;
        return c;
    endfunction

    task automatic push(input string nm, input logic r, input logic [5:0] op,
                        input logic [5:0] fn, input logic z, input ctl_t c);
        entry_t e;
        e.name = nm; e.rst = r; e.op = op; e.fn = fn; e.z = z; e.exp = c;
        q.push_back(e);
    endtask

    // Entered just after a posedge; each entry occupies one full clock cycle.
    task automatic drain();
        ctl_t   act;
        entry_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            rst_n = e.rst;
            bus.opcode = e.op;
            bus.funct = e.fn;
            bus.zero = e.z;
            @(negedge clk);
            act = {bus.state, bus.pc_write, bus.iord, bus.mem_read, bus.mem_write,
                   bus.ir_write, bus.reg_write, bus.reg_dst, bus.mem_to_reg,
                   bus.alu_src_a, bus.alu_src_b, bus.ext_zero, bus.pc_source,
                   bus.alu_ctrl, bus.instr_done};
            tests++;
            if (act !== e.exp) begin
                fails++;
                $display("FAIL %s: got %06h expected %06h", e.name, act, e.exp);
            end else begin
                $display("[TB] ok %s ctl=%06h", e.name, act);
            end
            @(posedge clk);
            #1;
        end
    endtask

    // FETCH is given a junk opcode to show it is ignored until DECODE.
    task automatic q_fetch(input string nm);
        push({nm, ".fetch"}, 1, 6'h3F, 6'h3F, 0, ex(4'd0, 0, 0, 0, 0));
    endtask

    task automatic q_lw(input string nm);
        q_fetch(nm);
        push({nm, ".decode"}, 1, 6'h23, 6'h00, 0, ex(4'd1, 0, 0, 0, 0));
        push({nm, ".memadr"}, 1, 6'h23, 6'h00, 0, ex(4'd2, 0, 0, 0, 0));
        push({nm, ".memrd"},  1, 6'h23, 6'h00, 0, ex(4'd3, 0, 0, 0, 0));
        push({nm, ".memwb"},  1, 6'h23, 6'h00, 0, ex(4'd4, 0, 0, 0, 0));
    endtask

    task automatic q_sw(input string nm);
        q_fetch(nm);
        push({nm, ".decode"}, 1, 6'h2B, 6'h00, 0, ex(4'd1, 0, 0, 0, 0));
        push({nm, ".memadr"}, 1, 6'h2B, 6'h00, 0, ex(4'd2, 0, 0, 0, 0));
        push({nm, ".memwr"},  1, 6'h2B, 6'h00, 0, ex(4'd5, 0, 0, 0, 0));
    endtask

    task automatic q_rt(input string nm, input logic [5:0] fn, input logic [3:0] alu);
        q_fetch(nm);
        push({nm, ".decode"}, 1, 6'h00, fn, 0, ex(4'd1, 0, 0, 0, 0));
        push({nm, ".rtex"},   1, 6'h00, fn, 0, ex(4'd6, alu, 0, 0, 0));
        push({nm, ".rtwb"},   1, 6'h00, fn, 0, ex(4'd7, 0, 0, 0, 0));
    endtask

    task automatic q_br(input string nm, input logic [5:0] op, input logic z, input logic pcw);
        q_fetch(nm);
        push({nm, ".decode"}, 1, op, 6'h00, z, ex(4'd1, 0, 0, 0, 0));
        push({nm, ".branch"}, 1, op, 6'h00, z, ex(4'd8, 0, 0, pcw, 0));
    endtask

    task automatic q_it(input string nm, input logic [5:0] op, input logic [3:0] alu, input logic ez);
        q_fetch(nm);
        push({nm, ".decode"}, 1, op, 6'h00, 0, ex(4'd1, 0, 0, 0, 0));
        push({nm, ".itex"},   1, op, 6'h00, 0, ex(4'd9, alu, ez, 0, 0));
        push({nm, ".itwb"},   1, op, 6'h00, 0, ex(4'd10, 0, 0, 0, 0));
    endtask

    task automatic q_j(input string nm);
        q_fetch(nm);
        push({nm, ".decode"}, 1, 6'h02, 6'h00, 0, ex(4'd1, 0, 0, 0, 0));
        push({nm, ".jump"},   1, 6'h02, 6'h00, 0, ex(4'd11, 0, 0, 0, 0));
    endtask

    task automatic q_nop(input string nm, input logic [5:0] op, input logic [5:0] fn);
        q_fetch(nm);
        push({nm, ".decode"}, 1, op, fn, 0, ex(4'd1, 0, 0, 0, 1));
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.opcode = 6'h3F; bus.funct = 6'h00; bus.zero = 1'b0;
        @(posedge clk);
        #1;
        push("reset.c1", 0, 6'h23, 6'h00, 0, held(4'd0));
        push("reset.c2", 0, 6'h2B, 6'h00, 1, held(4'd0));
        q_nop("reset.nop", 6'h3F, 6'h00);
        drain();
    endtask

    task automatic test_lw();
        q_lw("lw");
        drain();
    endtask

    task automatic test_sw();
        q_sw("sw");
        drain();
    endtask

    task automatic test_rtype();
        q_rt("sub", 6'h22, 4'd1);
        q_rt("nor", 6'h27, 4'd5);
        q_rt("slt", 6'h2A, 4'd6);
        q_nop("rt_bad_funct", 6'h00, 6'h21);
        drain();
    endtask

    task automatic test_branch();
        q_br("beq_z1", 6'h04, 1, 1);
        q_br("beq_z0", 6'h04, 0, 0);
        q_br("bne_z1", 6'h05, 1, 0);
        q_br("bne_z0", 6'h05, 0, 1);
        drain();
    endtask

    task automatic test_itype();
        q_it("ori",  6'h0D, 4'd3, 1);
        q_it("addi", 6'h08, 4'd0, 0);
        q_it("slti", 6'h0A, 4'd6, 0);
        q_it("andi", 6'h0C, 4'd2, 1);
        q_it("xori", 6'h0E, 4'd4, 1);
        drain();
    endtask

    task automatic test_jump_nop();
        q_j("j");
        q_nop("nop3f", 6'h3F, 6'h00);
        drain();
    endtask

    // Reset asserted during MEMWR: strobes drop at once, FETCH after release.
    task automatic test_reset_memwr();
        q_fetch("swrst");
        push("swrst.decode", 1, 6'h2B, 6'h00, 0, ex(4'd1, 0, 0, 0, 0));
        push("swrst.memadr", 1, 6'h2B, 6'h00, 0, ex(4'd2, 0, 0, 0, 0));
        push("swrst.memwr_rst", 0, 6'h2B, 6'h00, 0, held(4'd5));
        push("swrst.held",   0, 6'h2B, 6'h00, 0, held(4'd0));
        q_nop("swrst.after", 6'h3F, 6'h00);
        drain();
    endtask

    // Reset during MEMRD aborts the load: MEMWB never happens.
    task automatic test_reset_abort_lw();
        q_fetch("lwrst");
        push("lwrst.decode", 1, 6'h23, 6'h00, 0, ex(4'd1, 0, 0, 0, 0));
        push("lwrst.memadr", 1, 6'h23, 6'h00, 0, ex(4'd2, 0, 0, 0, 0));
        push("lwrst.memrd_rst", 0, 6'h23, 6'h00, 0, held(4'd3));
        q_j("lwrst.after");
        drain();
    endtask

    task automatic test_back_to_back();
        q_lw("b2b.lw");
        q_rt("b2b.and", 6'h24, 4'd2);
        q_br("b2b.beq", 6'h04, 1, 1);
        q_nop("b2b.nop", 6'h10, 6'h00);
        q_rt("b2b.or", 6'h25, 4'd3);
        q_rt("b2b.xor", 6'h26, 4'd4);
        q_rt("b2b.add", 6'h20, 4'd0);
        q_sw("b2b.sw");
        q_j("b2b.j");
        drain();
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw();
        test_rtype();
        test_branch();
        test_itype();
        test_jump_nop();
        test_reset_memwr();
        test_reset_abort_lw();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
